// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and TX-buffer-side signals of the UART TX arbiter.
// The arbiter takes the slave modport; the driving environment takes master.
interface uart_tx_arbiter_if #(
  parameter int unsigned IDW = 2
);
  localparam int unsigned NUM_REQ = 2**IDW;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack_c;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_busy;
  logic [IDW-1:0]       grant_id;
  logic                 active;

  modport master (
    output req_valid, req_data, req_last, out_busy,
    input  req_ack_c, out_data, out_valid, grant_id, active
  );

  modport slave (
    input  req_valid, req_data, req_last, out_busy,
    output req_ack_c, out_data, out_valid, grant_id, active
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX buffer between 2**IDW byte streams.
// A grant lasts until message end, MAX_BURST bytes, or TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int unsigned IDW       = 2,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned     NUM_REQ = 2**IDW;
  localparam int unsigned     CNTW    = 8;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [CNTW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [CNTW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic [IDW-1:0]     cand_c;
  logic [IDW-1:0]     pick_idx_c;
  logic               pick_found_c;
  logic               accept_c;
  logic [CNTW-1:0]    byte_inc_c;
  logic [CNTW-1:0]    idle_inc_c;
  logic [NUM_REQ-1:0] ack_c;

  // Circular search starting one past the last granted index.
  always_comb begin
    cand_c       = grant_q;
    pick_idx_c   = grant_q;
    pick_found_c = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_c = grant_q + IDW'(i);
      if (!pick_found_c && bus.req_valid[cand_c]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = cand_c;
      end
    end
  end

  assign accept_c   = (state_q == XFER) && bus.req_valid[grant_q] && !bus.out_busy;
  assign byte_inc_c = (byte_cnt_q == CNT_MAX) ? CNT_MAX : byte_cnt_q + CNTW'(1);
  assign idle_inc_c = (idle_cnt_q == CNT_MAX) ? CNT_MAX : idle_cnt_q + CNTW'(1);

  always_comb begin
    ack_c = '0;
    if (accept_c) begin
      ack_c[grant_q] = 1'b1;
    end
  end

  // Next-state: arbitration in IDLE, byte forwarding and release checks in XFER.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    byte_cnt_d  = byte_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    if (state_q == IDLE) begin
      if (pick_found_c) begin
        grant_d    = pick_idx_c;
        byte_cnt_d = '0;
        idle_cnt_d = '0;
        state_d    = XFER;
      end
    end else begin
      if (accept_c) begin
        out_data_d  = bus.req_data[{grant_q, 3'b000} +: 8];
        out_valid_d = 1'b1;
        byte_cnt_d  = byte_inc_c;
        idle_cnt_d  = '0;
        if (bus.req_last[grant_q] || (byte_inc_c >= CNTW'(MAX_BURST))) begin
          state_d = IDLE;
        end
      end else if (!bus.req_valid[grant_q]) begin
        // Backpressure stalls leave the idle count untouched.
        idle_cnt_d = idle_inc_c;
        if (idle_inc_c >= CNTW'(TIMEOUT)) begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= IDW'(NUM_REQ - 1);
      byte_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      byte_cnt_q  <= byte_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.req_ack_c = ack_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.grant_id  = grant_q;
  assign bus.active    = (state_q == XFER);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model and per-requester byte scoreboard.
module tb_uart_tx_arbiter;
  localparam int unsigned IDW       = 2;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned TIMEOUT   = 8;
  localparam int unsigned QD        = 2048;
  localparam int unsigned LD        = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.IDW(IDW)) bus();

  uart_tx_arbiter #(
    .IDW      (IDW),
    .MAX_BURST(MAX_BURST),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Requester message queues ({last, data}) and scoreboard read pointers.
  logic [8:0] rq_mem [NUM_REQ][QD];
  int         rq_head [NUM_REQ];
  int         rq_tail [NUM_REQ];
  int         sb_idx  [NUM_REQ];

  // Log of delivered bytes.
  int         log_n;
  logic [7:0] log_data [LD];
  int         log_gnt  [LD];
  int         log_cyc  [LD];

  // Reference model: who holds the grant, how many bytes sent, idle run length.
  logic       m_hold;
  int         m_grant;
  int         m_sent;
  int         m_wait;
  logic       m_ov;
  logic [7:0] m_od;

  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
    for (int off = 1; off <= int'(NUM_REQ); off++) begin
      if (v[(last + off) % NUM_REQ]) return (last + off) % NUM_REQ;
    end
    return last;
  endfunction

  function automatic logic [NUM_REQ-1:0] exp_ack();
    logic [NUM_REQ-1:0] r;
    r = '0;
    if (m_hold && bus.req_valid[m_grant] && !bus.out_busy) r[m_grant] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold  <= 1'b0;
      m_grant <= NUM_REQ - 1;
      m_sent  <= 0;
      m_wait  <= 0;
      m_ov    <= 1'b0;
      m_od    <= 8'h00;
    end else if (!m_hold) begin
      m_ov <= 1'b0;
      if (bus.req_valid != '0) begin
        m_grant <= rr_pick(m_grant, bus.req_valid);
        m_hold  <= 1'b1;
        m_sent  <= 0;
        m_wait  <= 0;
      end
    end else if (bus.req_valid[m_grant] && !bus.out_busy) begin
      m_ov   <= 1'b1;
      m_od   <= bus.req_data[m_grant*8 +: 8];
      m_sent <= m_sent + 1;
      m_wait <= 0;
      if (bus.req_last[m_grant] || (m_sent + 1 == int'(MAX_BURST))) m_hold <= 1'b0;
    end else begin
      m_ov <= 1'b0;
      if (!bus.req_valid[m_grant]) begin
        m_wait <= m_wait + 1;
        if (m_wait + 1 == int'(TIMEOUT)) m_hold <= 1'b0;
      end
    end
  end

  task automatic present();
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (rq_head[i] < rq_tail[i]) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_data[i*8 +: 8]  = rq_mem[i][rq_head[i]][7:0];
        bus.req_last[i]         = rq_mem[i][rq_head[i]][8];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[i*8 +: 8]  = 8'h00;
        bus.req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
      sb_idx[i]  = 0;
    end
    log_n = 0;
    present();
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic l);
    if (rq_tail[r] < int'(QD)) begin
      rq_mem[r][rq_tail[r]] = {l, d};
      rq_tail[r]++;
    end
  endtask

  // One clock: requesters advance on acks seen this cycle, deliveries are logged.
  task automatic step();
    logic [NUM_REQ-1:0] acked;
    @(negedge clk);
    acked = bus.req_ack_c;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.out_valid && log_n < int'(LD)) begin
      log_data[log_n] = bus.out_data;
      log_gnt[log_n]  = int'(bus.grant_id);
      log_cyc[log_n]  = cyc;
      log_n++;
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (acked[i] && rq_head[i] < rq_tail[i]) rq_head[i]++;
    end
    present();
    #1;
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    bus.out_busy = 1'b0;
    clear_queues();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = NUM_REQ'($urandom);
    bus.req_data  = $urandom;
    bus.req_last  = NUM_REQ'($urandom);
    bus.out_busy  = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.req_ack_c !== 4'b0000) $display("FAIL reset_ack got %b want 0000", bus.req_ack_c); else n_pass++;
    n_checks++; if (bus.active !== 1'b0) $display("FAIL reset_active got %b want 0", bus.active); else n_pass++;
    n_checks++; if (bus.grant_id !== 2'd3) $display("FAIL reset_grant got %0d want 3", bus.grant_id); else n_pass++;
    n_checks++; if (bus.out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", bus.out_data); else n_pass++;
    bus.out_busy = 1'b0;
    clear_queues();
    push_byte(0, 8'h41, 1'b1);
    present();
    rst_n = 1'b1;
    step();
    n_checks++; if (bus.active !== 1'b1) $display("FAIL first_active got %b want 1", bus.active); else n_pass++;
    n_checks++; if (bus.grant_id !== 2'd0) $display("FAIL first_grant got %0d want 0", bus.grant_id); else n_pass++;
    n_checks++; if (bus.req_ack_c !== 4'b0001) $display("FAIL first_ack got %b want 0001", bus.req_ack_c); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL first_early_valid got %b want 0", bus.out_valid); else n_pass++;
    step();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL first_out_valid got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== 8'h41) $display("FAIL first_out_data got %h want 41", bus.out_data); else n_pass++;
    n_checks++; if (bus.active !== 1'b0) $display("FAIL first_release got %b want 0", bus.active); else n_pass++;
    step();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL first_pulse_width got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_round_robin();
    int         eg [5];
    logic [7:0] ed [5];
    eg = '{0, 1, 2, 3, 0};
    ed = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    apply_reset();
    push_byte(0, 8'h41, 1'b1);
    push_byte(1, 8'h42, 1'b1);
    push_byte(2, 8'h43, 1'b1);
    push_byte(3, 8'h44, 1'b1);
    push_byte(0, 8'h45, 1'b1);
    present();
    for (int t = 0; t < 40 && log_n < 5; t++) step();
    n_checks++; if (log_n < 5) $display("FAIL rr_budget got %0d bytes want 5", log_n); else n_pass++;
    for (int k = 0; k < 5 && k < log_n; k++) begin
      n_checks++; if (log_gnt[k] != eg[k]) $display("FAIL rr_grant[%0d] got %0d want %0d", k, log_gnt[k], eg[k]); else n_pass++;
      n_checks++; if (log_data[k] !== ed[k]) $display("FAIL rr_data[%0d] got %h want %h", k, log_data[k], ed[k]); else n_pass++;
      if (k > 0) begin
        n_checks++; if (log_cyc[k] - log_cyc[k-1] != 2) $display("FAIL rr_gap[%0d] got %0d want 2", k, log_cyc[k] - log_cyc[k-1]); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    clear_queues();
    push_byte(1, 8'h45, 1'b0);
    push_byte(1, 8'h46, 1'b0);
    push_byte(1, 8'h47, 1'b1);
    present();
    for (int t = 0; t < 10 && log_n < 1; t++) step();
    n_checks++; if (log_n < 1) $display("FAIL bp_start_budget got %0d bytes want 1", log_n); else n_pass++;
    bus.out_busy = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.req_ack_c !== 4'b0000) $display("FAIL bp_ack[%0d] got %b want 0000", k, bus.req_ack_c); else n_pass++;
      step();
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_valid[%0d] got %b want 0", k, bus.out_valid); else n_pass++;
      n_checks++; if (bus.active !== 1'b1) $display("FAIL bp_hold[%0d] got %b want 1", k, bus.active); else n_pass++;
    end
    bus.out_busy = 1'b0;
    for (int t = 0; t < 10 && log_n < 3; t++) step();
    n_checks++; if (log_n < 3) $display("FAIL bp_end_budget got %0d bytes want 3", log_n); else n_pass++;
    for (int k = 0; k < 3 && k < log_n; k++) begin
      n_checks++; if (log_gnt[k] != 1) $display("FAIL bp_grant[%0d] got %0d want 1", k, log_gnt[k]); else n_pass++;
      n_checks++; if (log_data[k] !== 8'(8'h45 + k)) $display("FAIL bp_data[%0d] got %h want %h", k, log_data[k], 8'(8'h45 + k)); else n_pass++;
    end
    n_checks++; if (bus.active !== 1'b0) $display("FAIL bp_release got %b want 0", bus.active); else n_pass++;
  endtask

  task automatic test_burst_limit();
    int         eg [7];
    logic [7:0] ed [7];
    eg = '{2, 2, 2, 2, 3, 2, 2};
    ed = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h54, 8'h55};
    clear_queues();
    for (int k = 0; k < 6; k++) push_byte(2, 8'(8'h50 + k), (k == 5));
    push_byte(3, 8'h60, 1'b1);
    present();
    for (int t = 0; t < 40 && log_n < 7; t++) step();
    n_checks++; if (log_n < 7) $display("FAIL burst_budget got %0d bytes want 7", log_n); else n_pass++;
    for (int k = 0; k < 7 && k < log_n; k++) begin
      n_checks++; if (log_gnt[k] != eg[k]) $display("FAIL burst_grant[%0d] got %0d want %0d", k, log_gnt[k], eg[k]); else n_pass++;
      n_checks++; if (log_data[k] !== ed[k]) $display("FAIL burst_data[%0d] got %h want %h", k, log_data[k], ed[k]); else n_pass++;
    end
    if (log_n >= 2) begin
      n_checks++; if (log_cyc[1] - log_cyc[0] != 1) $display("FAIL burst_b2b got %0d want 1", log_cyc[1] - log_cyc[0]); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int a_cyc;
    int r_cyc;
    clear_queues();
    push_byte(0, 8'h70, 1'b0);
    push_byte(0, 8'h71, 1'b0);
    push_byte(1, 8'h72, 1'b1);
    present();
    for (int t = 0; t < 10 && log_n < 2; t++) step();
    n_checks++; if (log_n < 2) $display("FAIL to_start_budget got %0d bytes want 2", log_n); else n_pass++;
    a_cyc = cyc;
    r_cyc = -1;
    for (int t = 0; t < 20 && r_cyc < 0; t++) begin
      step();
      if (bus.active == 1'b0) r_cyc = cyc;
    end
    n_checks++; if (r_cyc - a_cyc != int'(TIMEOUT)) $display("FAIL to_release_delay got %0d want %0d", r_cyc - a_cyc, TIMEOUT); else n_pass++;
    n_checks++; if (bus.grant_id !== 2'd0) $display("FAIL to_grant_kept got %0d want 0", bus.grant_id); else n_pass++;
    for (int t = 0; t < 10 && log_n < 3; t++) step();
    n_checks++; if (log_n < 3) $display("FAIL to_next_budget got %0d bytes want 3", log_n); else n_pass++;
    n_checks++; if (log_gnt[2] != 1 || log_data[2] !== 8'h72) $display("FAIL to_next got %0d:%h want 1:72", log_gnt[2], log_data[2]); else n_pass++;
    n_checks++; if (bus.grant_id !== 2'd1) $display("FAIL to_grant_after got %0d want 1", bus.grant_id); else n_pass++;
  endtask

  task automatic test_async_reset();
    clear_queues();
    for (int k = 0; k < 5; k++) push_byte(0, 8'(8'h80 + k), (k == 4));
    present();
    for (int t = 0; t < 10 && log_n < 2; t++) step();
    n_checks++; if (log_n < 2) $display("FAIL ar_start_budget got %0d bytes want 2", log_n); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL ar_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.active !== 1'b0) $display("FAIL ar_active got %b want 0", bus.active); else n_pass++;
    n_checks++; if (bus.grant_id !== 2'd3) $display("FAIL ar_grant got %0d want 3", bus.grant_id); else n_pass++;
    n_checks++; if (bus.req_ack_c !== 4'b0000) $display("FAIL ar_ack got %b want 0000", bus.req_ack_c); else n_pass++;
    n_checks++; if (bus.out_data !== 8'h00) $display("FAIL ar_out_data got %h want 00", bus.out_data); else n_pass++;
    clear_queues();
    push_byte(1, 8'h91, 1'b1);
    push_byte(0, 8'h90, 1'b1);
    present();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 20 && log_n < 2; t++) step();
    n_checks++; if (log_n < 2) $display("FAIL ar_restart_budget got %0d bytes want 2", log_n); else n_pass++;
    n_checks++; if (log_gnt[0] != 0 || log_data[0] !== 8'h90) $display("FAIL ar_first got %0d:%h want 0:90", log_gnt[0], log_data[0]); else n_pass++;
    n_checks++; if (log_gnt[1] != 1 || log_data[1] !== 8'h91) $display("FAIL ar_second got %0d:%h want 1:91", log_gnt[1], log_data[1]); else n_pass++;
  endtask

  task automatic test_random();
    int g;
    apply_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int r = 0; r < int'(NUM_REQ); r++) begin
        if (rq_head[r] == rq_tail[r] && ($urandom % 5) == 0 && rq_tail[r] < int'(QD) - 8) begin
          int len;
          len = 1 + int'($urandom % 6);
          for (int k = 0; k < len; k++) push_byte(r, 8'($urandom), (k == len - 1));
        end
      end
      bus.out_busy = (($urandom % 4) == 0);
      present();
      #1;
      n_checks++; if (bus.req_ack_c !== exp_ack()) $display("FAIL rnd_ack@%0d got %b want %b", cyc, bus.req_ack_c, exp_ack()); else n_pass++;
      step();
      n_checks++; if (bus.out_valid !== m_ov) $display("FAIL rnd_valid@%0d got %b want %b", cyc, bus.out_valid, m_ov); else n_pass++;
      n_checks++; if (bus.active !== m_hold) $display("FAIL rnd_active@%0d got %b want %b", cyc, bus.active, m_hold); else n_pass++;
      n_checks++; if (bus.grant_id !== IDW'(m_grant)) $display("FAIL rnd_grant@%0d got %0d want %0d", cyc, bus.grant_id, m_grant); else n_pass++;
      if (m_ov) begin
        n_checks++; if (bus.out_data !== m_od) $display("FAIL rnd_data@%0d got %h want %h", cyc, bus.out_data, m_od); else n_pass++;
        g = m_grant;
        if (sb_idx[g] < rq_tail[g]) begin
          n_checks++;
          if (bus.out_data !== rq_mem[g][sb_idx[g]][7:0])
            $display("FAIL rnd_order@%0d req %0d got %h want %h", cyc, g, bus.out_data, rq_mem[g][sb_idx[g]][7:0]);
          else n_pass++;
          sb_idx[g]++;
        end
      end
    end
    bus.out_busy = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.out_busy  = 1'b0;
    log_n         = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_burst_limit();
    test_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
